// File: rtl/bram_prefetch_reader_pkg.sv
// Shared types and default sizing for the BRAM prefetch reader.
package bram_reader_pkg;

    localparam int BYTE_BITS         = 8;
    localparam int DEFAULT_DATA_BITS = BYTE_BITS;
    localparam int DEFAULT_DEPTH     = 4;

    typedef enum logic {
        B_IDLE,
        B_WAIT
    } bram_state_e;

    typedef enum logic {
        R_IDLE,
        R_BUSY
    } reader_state_e;

endpackage

// File: rtl/bram_prefetch_reader_if.sv
// Handshake bundle between the BRAM source, the prefetch reader and the consumer.
interface bram_prefetch_reader_if
    import bram_reader_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int DEPTH     = DEFAULT_DEPTH
);
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    logic                 flush;
    logic                 is_empty;
    logic                 bram_rdy;
    logic                 bram_done;
    logic [DATA_BITS-1:0] bram_data;
    logic                 reader_rdy;
    logic                 reader_done;
    logic                 bram_trigger;
    logic                 reader_trigger;
    logic [DATA_BITS-1:0] reader_data;
    logic [CNT_BITS-1:0]  fill_count;

    // Reader side: consumes BRAM/consumer status, drives the triggers.
    modport slave (
        input  flush, is_empty, bram_rdy, bram_done, bram_data, reader_rdy, reader_done,
        output bram_trigger, reader_trigger, reader_data, fill_count
    );

    modport master (
        output flush, is_empty, bram_rdy, bram_done, bram_data, reader_rdy, reader_done,
        input  bram_trigger, reader_trigger, reader_data, fill_count
    );

endinterface

// File: rtl/bram_prefetch_fifo.sv
// Circular prefetch buffer; only pointers and count are reset, storage is not.
module bram_prefetch_fifo
    import bram_reader_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int DEPTH     = DEFAULT_DEPTH,
    localparam int CNT_BITS = $clog2(DEPTH + 1),
    localparam int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 clear,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata,
    output logic [CNT_BITS-1:0]  count
);
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_BITS-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_BITS-1:0]  count_reg, count_next;

    // Head is read combinationally so a word pushed on one edge can be popped on the next.
    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_comb begin
        wr_ptr_next = push ? wr_ptr_reg + PTR_BITS'(1) : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + PTR_BITS'(1) : rd_ptr_reg;
        count_next  = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_BITS'(1);
            2'b01:   count_next = count_reg - CNT_BITS'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

endmodule

// File: rtl/bram_prefetch_reader.sv
// Streams BRAM words to a consumer through a prefetch FIFO, hiding BRAM read latency.
module bram_prefetch_reader
    import bram_reader_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    bram_prefetch_reader_if.slave bus
);
    localparam int CNT_BITS = $clog2(DEPTH + 1);

    bram_state_e          b_state_reg;
    reader_state_e        r_state_reg;
    logic                 drop_reg;
    logic                 bram_trigger_reg;
    logic                 reader_trigger_reg;
    logic [DATA_BITS-1:0] reader_data_reg;

    logic [DATA_BITS-1:0] fifo_rdata;
    logic [CNT_BITS-1:0]  fifo_count;
    logic                 bram_issue;
    logic                 reader_issue;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_clear;

    assign bram_issue   = (b_state_reg == B_IDLE) && !bus.is_empty && bus.bram_rdy &&
                          (fifo_count < CNT_BITS'(DEPTH)) && !bus.flush;
    assign reader_issue = (r_state_reg == R_IDLE) && (fifo_count != '0) &&
                          bus.reader_rdy && !bus.flush;

    // A word returning after a flush belongs to the discarded stream.
    assign fifo_push  = clk_en && (b_state_reg == B_WAIT) && bus.bram_done && !drop_reg;
    assign fifo_pop   = clk_en && reader_issue;
    assign fifo_clear = clk_en && bus.flush;

    bram_prefetch_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .wdata (bus.bram_data),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_state_reg      <= B_IDLE;
            drop_reg         <= 1'b0;
            bram_trigger_reg <= 1'b0;
        end else if (clk_en) begin
            bram_trigger_reg <= bram_issue;
            case (b_state_reg)
                B_IDLE: begin
                    if (bram_issue) begin
                        b_state_reg <= B_WAIT;
                    end
                end
                B_WAIT: begin
                    if (bus.bram_done) begin
                        b_state_reg <= B_IDLE;
                        drop_reg    <= 1'b0;
                    end else if (bus.flush) begin
                        drop_reg <= 1'b1;
                    end
                end
                default: b_state_reg <= B_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_reg        <= R_IDLE;
            reader_trigger_reg <= 1'b0;
            reader_data_reg    <= '0;
        end else if (clk_en) begin
            reader_trigger_reg <= reader_issue;
            case (r_state_reg)
                R_IDLE: begin
                    if (reader_issue) begin
                        r_state_reg     <= R_BUSY;
                        reader_data_reg <= fifo_rdata;
                    end
                end
                R_BUSY: begin
                    if (bus.reader_done) begin
                        r_state_reg <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    assign bus.bram_trigger   = bram_trigger_reg;
    assign bus.reader_trigger = reader_trigger_reg;
    assign bus.reader_data    = reader_data_reg;
    assign bus.fill_count     = fifo_count;

endmodule
